rgb_pwm_driver: RTL

//   Consumes the 7-bit R/G/B duty ratios produced by the LED colour controllers and drives three
//   LED pins with glitch-free PWM. Duties are sampled only at period boundaries, so mid-period

---
 rtl/rgb_pwm_driver_pkg.sv | 14 +
 rtl/rgb_pwm_driver_channel.sv | 51 +++++
 rtl/rgb_pwm_driver.sv | 99 +++++++++
 3 files changed

// File: rtl/rgb_pwm_driver_pkg.sv
// Shared LED constants used by the PWM driver and the colour controllers,
// plus the phase-offset helper used when RGB_PWM_PHASE_STAGGER_EN is defined.
package rgb_pwm_driver_pkg;

  localparam int unsigned C_LED_DUTY_W     = 7;
  localparam int unsigned C_LED_PWM_PERIOD = 100;

  // Channel idx (0=R,1=G,2=B) starts its period idx/3 of the way through R's period.
  function automatic int unsigned f_phase_offset(input int unsigned period,
                                                 input int unsigned idx);
    return (period * idx) / 3;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM channel: duty shadow latched at its own period start, compare, registered pin.
// P_OFFSET shifts this channel's period start relative to the shared step counter.
module rgb_pwm_channel
  import rgb_pwm_driver_pkg::*;
#(
  parameter int unsigned P_DUTY_W     = C_LED_DUTY_W,
  parameter int unsigned P_PERIOD     = C_LED_PWM_PERIOD,
  parameter bit          P_ACTIVE_LOW = 1'b0,
  parameter int unsigned P_OFFSET     = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ce_i,
  input  logic                enable_i,
  input  logic [P_DUTY_W-1:0] step_i,
  input  logic [P_DUTY_W-1:0] duty_i,
  output logic                led_o
);

  localparam int unsigned L_CW = P_DUTY_W + 1;

  logic [L_CW-1:0]     loc_sum;
  logic [L_CW-1:0]     loc;
  logic                at_zero;
  logic [P_DUTY_W-1:0] duty_sel;
  logic                lit_d;
  logic [P_DUTY_W-1:0] shadow_q;
  logic                led_q;

  // Local step = (step - offset) mod period, formed as step + (period - offset) to stay unsigned.
  always_comb begin
    loc_sum  = {1'b0, step_i} + L_CW'(P_PERIOD - P_OFFSET);
    loc      = (loc_sum >= L_CW'(P_PERIOD)) ? loc_sum - L_CW'(P_PERIOD) : loc_sum;
    at_zero  = (loc == '0);
    duty_sel = at_zero ? duty_i : shadow_q;
    lit_d    = enable_i & (loc < {1'b0, duty_sel});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      led_q    <= P_ACTIVE_LOW;
    end else if (ce_i) begin
      if (at_zero) shadow_q <= duty_i;
      led_q <= lit_d ^ P_ACTIVE_LOW;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel glitch-free PWM LED driver; duties are sampled only at period boundaries.
// Optional RGB_PWM_PHASE_STAGGER_EN offsets G/B by 1/3 and 2/3 of a period.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int unsigned P_DUTY_W     = C_LED_DUTY_W,
  parameter int unsigned P_PERIOD     = C_LED_PWM_PERIOD,
  parameter bit          P_ACTIVE_LOW = 1'b0
) (
  input  logic                I_CLK_100MHZ,
  input  logic                I_RST_N,
  input  logic                I_CE_PWM,
  input  logic                I_ENABLE,
  input  logic [P_DUTY_W-1:0] I_DUTY_R,
  input  logic [P_DUTY_W-1:0] I_DUTY_G,
  input  logic [P_DUTY_W-1:0] I_DUTY_B,
  output logic                O_LED_R,
  output logic                O_LED_G,
  output logic                O_LED_B,
  output logic                O_PERIOD_START
);

`ifdef RGB_PWM_PHASE_STAGGER_EN
  localparam int unsigned L_OFF_G = f_phase_offset(P_PERIOD, 1);
  localparam int unsigned L_OFF_B = f_phase_offset(P_PERIOD, 2);
`else
  localparam int unsigned L_OFF_G = 0;
  localparam int unsigned L_OFF_B = 0;
`endif

  logic [P_DUTY_W-1:0] cnt_q;
  logic [P_DUTY_W-1:0] cnt_d;
  logic                wrap;
  logic                period_start_q;

  always_comb begin
    wrap  = (cnt_q == P_DUTY_W'(P_PERIOD - 1));
    cnt_d = wrap ? '0 : cnt_q + P_DUTY_W'(1);
  end

  // Counter resets to the last step so the first CE after release opens a fresh period.
  always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
    if (!I_RST_N) begin
      cnt_q          <= P_DUTY_W'(P_PERIOD - 1);
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= I_CE_PWM & wrap;
      if (I_CE_PWM) cnt_q <= cnt_d;
    end
  end

  assign O_PERIOD_START = period_start_q;

  rgb_pwm_channel #(
    .P_DUTY_W    (P_DUTY_W),
    .P_PERIOD    (P_PERIOD),
    .P_ACTIVE_LOW(P_ACTIVE_LOW),
    .P_OFFSET    (0)
  ) u_ch_r (
    .clk_i   (I_CLK_100MHZ),
    .rst_ni  (I_RST_N),
    .ce_i    (I_CE_PWM),
    .enable_i(I_ENABLE),
    .step_i  (cnt_d),
    .duty_i  (I_DUTY_R),
    .led_o   (O_LED_R)
  );

  rgb_pwm_channel #(
    .P_DUTY_W    (P_DUTY_W),
    .P_PERIOD    (P_PERIOD),
    .P_ACTIVE_LOW(P_ACTIVE_LOW),
    .P_OFFSET    (L_OFF_G)
  ) u_ch_g (
    .clk_i   (I_CLK_100MHZ),
    .rst_ni  (I_RST_N),
    .ce_i    (I_CE_PWM),
    .enable_i(I_ENABLE),
    .step_i  (cnt_d),
    .duty_i  (I_DUTY_G),
    .led_o   (O_LED_G)
  );

  rgb_pwm_channel #(
    .P_DUTY_W    (P_DUTY_W),
    .P_PERIOD    (P_PERIOD),
    .P_ACTIVE_LOW(P_ACTIVE_LOW),
    .P_OFFSET    (L_OFF_B)
  ) u_ch_b (
    .clk_i   (I_CLK_100MHZ),
    .rst_ni  (I_RST_N),
    .ce_i    (I_CE_PWM),
    .enable_i(I_ENABLE),
    .step_i  (cnt_d),
    .duty_i  (I_DUTY_B),
    .led_o   (O_LED_B)
  );

endmodule
